// File: rtl/alu_seq_exec.sv
// Sequential ALU/branch execute unit with valid/ready handshake.
// Shifts retire one bit per cycle; all other codes complete in one cycle.
module alu_seq_exec (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  aluctrl,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        branch_taken,
  output logic        zero,
  output logic        illegal
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  sop_q, sop_d;
  logic        sign_q, sign_d;
  logic        br_q, br_d;
  logic        ill_q, ill_d;
  logic        zero_q, zero_d;

  logic        accept;
  logic        is_shift;
  logic [4:0]  shamt;
  logic [31:0] alu_res;
  logic        alu_br;
  logic        alu_ill;
  logic [31:0] shifted;

  assign accept   = in_ready && in_valid && !flush;
  assign shamt    = srcb[4:0];
  assign is_shift = (aluctrl == 5'd5) || (aluctrl == 5'd6) ||
                    (aluctrl == 5'd7);

  always_comb begin
    alu_res = '0;
    alu_br  = 1'b0;
    alu_ill = 1'b0;
    case (aluctrl)
      5'd0:  alu_res = srca + srcb;
      5'd1:  alu_res = srca - srcb;
      5'd2:  alu_res = srca ^ srcb;
      5'd3:  alu_res = srca | srcb;
      5'd4:  alu_res = srca & srcb;
      5'd5,
      5'd6,
      5'd7:  alu_res = srca;
      5'd8:  alu_res = {31'd0, $signed(srca) < $signed(srcb)};
      5'd9:  alu_res = {31'd0, srca < srcb};
      5'd10: alu_br  = (srca == srcb);
      5'd11: alu_br  = (srca != srcb);
      5'd12: alu_br  = ($signed(srca) < $signed(srcb));
      5'd13: alu_br  = ($signed(srca) >= $signed(srcb));
      5'd14: alu_br  = (srca < srcb);
      5'd15: alu_br  = (srca >= srcb);
      5'd16: alu_res = srcb;
      default: alu_ill = 1'b1;
    endcase
  end

  // sop: 01 sll, 10 srl, 11 sra (low bits of the shift codes)
  always_comb begin
    shifted = acc_q;
    case (sop_q)
      2'b01:   shifted = {acc_q[30:0], 1'b0};
      2'b10:   shifted = {1'b0, acc_q[31:1]};
      2'b11:   shifted = {sign_q, acc_q[31:1]};
      default: shifted = acc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:
          if (accept)
            state_d = (is_shift && shamt != 5'd0) ? S_SHIFT : S_DONE;
        S_SHIFT:
          if (cnt_q == 5'd1) state_d = S_DONE;
        S_DONE:
          if (out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    sop_d  = sop_q;
    sign_d = sign_q;
    br_d   = br_q;
    ill_d  = ill_q;
    zero_d = zero_q;
    if (accept) begin
      br_d  = alu_br;
      ill_d = alu_ill;
      if (is_shift && shamt != 5'd0) begin
        acc_d  = srca;
        cnt_d  = shamt;
        sop_d  = aluctrl[1:0];
        sign_d = srca[31];
        zero_d = 1'b0;
      end else begin
        acc_d  = alu_res;
        cnt_d  = 5'd0;
        zero_d = (alu_res == 32'd0);
      end
    end else if (state_q == S_SHIFT) begin
      acc_d  = shifted;
      cnt_d  = cnt_q - 5'd1;
      zero_d = (shifted == 32'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      sop_q  <= '0;
      sign_q <= 1'b0;
      br_q   <= 1'b0;
      ill_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      sop_q  <= sop_d;
      sign_q <= sign_d;
      br_q   <= br_d;
      ill_q  <= ill_d;
      zero_q <= zero_d;
    end
  end

  always_comb begin
    in_ready     = (state_q == S_IDLE) && !rst;
    out_valid    = (state_q == S_DONE);
    result       = acc_q;
    branch_taken = br_q;
    zero         = zero_q;
    illegal      = ill_q;
  end

endmodule
